// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register followed by the select between the
// ALU result and extracted/extended load data. Drives the register-file write port,
// flags misaligned loads and counts retired instructions.
// Optional feature: define WB_BYPASS_EN to add a one-cycle bypass of the last
// committed register write (byp_valid / byp_rn / byp_data).
module wb_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r_alu,
  input  logic [DATA_W-1:0] in_m_o,
  input  logic              in_m2reg,
  input  logic              in_wreg,
  input  logic [REG_AW-1:0] in_rn,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [OFF_W-1:0]  in_addr_lo,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rn,
  output logic [DATA_W-1:0] wb_wdi,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_rn,
  output logic [DATA_W-1:0] byp_data
`endif
);

  // Doubleword loads only exist on a 64-bit datapath; otherwise size 3 acts as word.
  localparam bit HasDword = (DATA_W == 64);

  // Load size encodings
  localparam logic [1:0] SzByte  = 2'd0;
  localparam logic [1:0] SzHalf  = 2'd1;
  localparam logic [1:0] SzWord  = 2'd2;
  localparam logic [1:0] SzDword = 2'd3;

  // Registered entry
  logic              v_q;
  logic [DATA_W-1:0] r_alu_q;
  logic [DATA_W-1:0] m_o_q;
  logic              m2reg_q;
  logic              wreg_q;
  logic [REG_AW-1:0] rn_q;
  logic [1:0]        ld_size_q;
  logic              ld_signed_q;
  logic [OFF_W-1:0]  addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;

  // Handshake / commit qualifiers
  logic capture;
  logic commit;

  // Load extraction intermediates
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              is_dword;
  logic [OFF_W-1:0]  eff_off;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ld_data;
  logic              misalign_cond;

  // A held entry blocks the input only while it is stalled.
  assign in_ready = !v_q | !stall;

  // Reset also suppresses the commit so a mid-stream reset writes nothing.
  assign commit  = v_q & !stall & !flush & !rst;
  assign capture = in_valid & in_ready & !flush;

  // Valid bit: flush beats capture, capture beats the drop after a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (capture) begin
      v_q <= 1'b1;
    end else if (commit) begin
      v_q <= 1'b0;
    end
  end

  // Entry fields load only on an accepted capture and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_q     <= '0;
      m_o_q       <= '0;
      m2reg_q     <= 1'b0;
      wreg_q      <= 1'b0;
      rn_q        <= '0;
      ld_size_q   <= 2'd0;
      ld_signed_q <= 1'b0;
      addr_lo_q   <= '0;
    end else if (capture) begin
      r_alu_q     <= in_r_alu;
      m_o_q       <= in_m_o;
      m2reg_q     <= in_m2reg;
      wreg_q      <= in_wreg;
      rn_q        <= in_rn;
      ld_size_q   <= in_ld_size;
      ld_signed_q <= in_ld_signed;
      addr_lo_q   <= in_addr_lo;
    end
  end

  // Retire counter counts every commit, including ones that write no register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Decode the load size into one-hot flags.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_dword = 1'b0;
    unique case (ld_size_q)
      SzByte:  is_byte = 1'b1;
      SzHalf:  is_half = 1'b1;
      SzWord:  is_word = 1'b1;
      SzDword: begin
        if (HasDword) begin
          is_dword = 1'b1;
        end else begin
          is_word = 1'b1;
        end
      end
      default: is_word = 1'b1;
    endcase
  end

  // Offset bits below the access size are ignored, truncating to the aligned lane.
  always_comb begin
    eff_off = addr_lo_q;
    if (is_half) begin
      eff_off = addr_lo_q & ~OFF_W'(1);
    end else if (is_word) begin
      eff_off = addr_lo_q & ~OFF_W'(3);
    end else if (is_dword) begin
      eff_off = '0;
    end
  end

  assign lane = m_o_q >> {eff_off, 3'b000};

  // Extract the addressed lane and sign/zero-extend it to the datapath width.
  always_comb begin
    ld_data = '0;
    if (is_byte) begin
      ld_data      = {DATA_W{ld_signed_q & lane[7]}};
      ld_data[7:0] = lane[7:0];
    end else if (is_half) begin
      ld_data       = {DATA_W{ld_signed_q & lane[15]}};
      ld_data[15:0] = lane[15:0];
    end else if (is_word) begin
      ld_data       = {DATA_W{ld_signed_q & lane[31]}};
      ld_data[31:0] = lane[31:0];
    end else begin
      ld_data = m_o_q;
    end
  end

  // A load is misaligned when any offset bit below its size is set.
  always_comb begin
    misalign_cond = (is_half  & addr_lo_q[0])
                  | (is_word  & (addr_lo_q[1:0] != 2'b00))
                  | (is_dword & (addr_lo_q != '0));
  end

  assign wb_we       = commit & wreg_q & (rn_q != '0);
  assign wb_rn       = rn_q;
  assign wb_wdi      = m2reg_q ? ld_data : r_alu_q;
  assign wb_misalign = commit & m2reg_q & misalign_cond;
  assign retire_cnt  = cnt_q;

`ifdef WB_BYPASS_EN
  logic              byp_valid_q;
  logic [REG_AW-1:0] byp_rn_q;
  logic [DATA_W-1:0] byp_data_q;

  // Hold the last register-file write for one cycle, for register files
  // that do not forward a same-cycle write to their read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_valid_q <= 1'b0;
      byp_rn_q    <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= wb_we;
      if (wb_we) begin
        byp_rn_q   <= rn_q;
        byp_data_q <= wb_wdi;
      end
    end
  end

  assign byp_valid = byp_valid_q;
  assign byp_rn    = byp_rn_q;
  assign byp_data  = byp_data_q;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (32-bit datapath, 8-bit retire counter so
// the wrap is reachable quickly). Bypass checks run when WB_BYPASS_EN is defined.
module tb_wb_stage_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r_alu;
  logic [DATA_W-1:0] in_m_o;
  logic              in_m2reg;
  logic              in_wreg;
  logic [REG_AW-1:0] in_rn;
  logic [1:0]        in_ld_size;
  logic              in_ld_signed;
  logic [1:0]        in_addr_lo;
  logic              stall;
  logic              flush;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rn;
  logic [DATA_W-1:0] wb_wdi;
  logic              wb_misalign;
  logic [CNT_W-1:0]  retire_cnt;
`ifdef WB_BYPASS_EN
  logic              byp_valid;
  logic [REG_AW-1:0] byp_rn;
  logic [DATA_W-1:0] byp_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage_pipe #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r_alu    (in_r_alu),
    .in_m_o      (in_m_o),
    .in_m2reg    (in_m2reg),
    .in_wreg     (in_wreg),
    .in_rn       (in_rn),
    .in_ld_size  (in_ld_size),
    .in_ld_signed(in_ld_signed),
    .in_addr_lo  (in_addr_lo),
    .stall       (stall),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rn       (wb_rn),
    .wb_wdi      (wb_wdi),
    .wb_misalign (wb_misalign),
    .retire_cnt  (retire_cnt)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid   (byp_valid),
    .byp_rn      (byp_rn),
    .byp_data    (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one load for a single cycle; returns with it registered and inputs idle.
  task automatic drive_load(input logic [31:0] mo, input logic [1:0] sz, input logic [1:0] off,
                            input logic sgn, input logic [4:0] rn);
    in_valid     = 1'b1;
    in_m2reg     = 1'b1;
    in_wreg      = 1'b1;
    in_m_o       = mo;
    in_ld_size   = sz;
    in_addr_lo   = off;
    in_ld_signed = sgn;
    in_rn        = rn;
    in_r_alu     = 32'h0BAD_0BAD;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_r_alu     = '0;
    in_m_o       = '0;
    in_m2reg     = 1'b0;
    in_wreg      = 1'b0;
    in_rn        = '0;
    in_ld_size   = 2'd0;
    in_ld_signed = 1'b0;
    in_addr_lo   = 2'd0;
    stall        = 1'b0;
    flush        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_rn", 64'(wb_rn), 64'd0);
    chk("rst_wdi", 64'(wb_wdi), 64'd0);
    chk("rst_mis", 64'(wb_misalign), 64'd0);
    chk("rst_cnt", 64'(retire_cnt), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
`ifdef WB_BYPASS_EN
    chk("rst_byp", 64'(byp_valid), 64'd0);
`endif

    // ALU path
    in_valid = 1'b1;
    in_r_alu = 32'h1234_5678;
    in_m2reg = 1'b0;
    in_wreg  = 1'b1;
    in_rn    = 5'd5;
    tick();
    in_valid = 1'b0;
    #1;
    chk("alu_we", 64'(wb_we), 64'd1);
    chk("alu_rn", 64'(wb_rn), 64'd5);
    chk("alu_wdi", 64'(wb_wdi), 64'h1234_5678);
    tick();
    chk("alu_cnt", 64'(retire_cnt), 64'd1);
    chk("alu_we_drop", 64'(wb_we), 64'd0);

    // Signed and unsigned byte at offset 3
    drive_load(32'h80FF_7F01, 2'd0, 2'd3, 1'b1, 5'd2);
    chk("sb_wdi", 64'(wb_wdi), 64'hFFFF_FF80);
    chk("sb_mis", 64'(wb_misalign), 64'd0);
    tick();
    drive_load(32'h80FF_7F01, 2'd0, 2'd3, 1'b0, 5'd2);
    chk("ub_wdi", 64'(wb_wdi), 64'h0000_0080);
    tick();

    // Misaligned unsigned half: offset bit 0 dropped
    drive_load(32'hBEEF_1234, 2'd1, 2'd3, 1'b0, 5'd3);
    chk("uh_wdi", 64'(wb_wdi), 64'h0000_BEEF);
    chk("uh_mis", 64'(wb_misalign), 64'd1);
    chk("uh_we", 64'(wb_we), 64'd1);
    tick();
    chk("uh_mis_drop", 64'(wb_misalign), 64'd0);

    // Misaligned word still writes the whole word
    drive_load(32'hDEAD_BEEF, 2'd2, 2'd1, 1'b1, 5'd4);
    chk("w_wdi", 64'(wb_wdi), 64'hDEAD_BEEF);
    chk("w_mis", 64'(wb_misalign), 64'd1);
    tick();

    // Size 3 on 32-bit datapath acts as an aligned word
    drive_load(32'h89AB_CDEF, 2'd3, 2'd0, 1'b1, 5'd4);
    chk("d32_wdi", 64'(wb_wdi), 64'h89AB_CDEF);
    chk("d32_mis", 64'(wb_misalign), 64'd0);
    tick();

    // Aligned signed half
    drive_load(32'h1234_F00D, 2'd1, 2'd0, 1'b1, 5'd6);
    chk("sh_wdi", 64'(wb_wdi), 64'hFFFF_F00D);
    chk("sh_mis", 64'(wb_misalign), 64'd0);
    tick();
    chk("ld_cnt", 64'(retire_cnt), 64'd7);

    // Back-to-back ALU instructions, one per cycle
    in_m2reg = 1'b0;
    in_wreg  = 1'b1;
    in_valid = 1'b1;
    in_r_alu = 32'hAAAA_0001;
    in_rn    = 5'd3;
    tick();
    in_r_alu = 32'hBBBB_0002;
    in_rn    = 5'd4;
    #1;
    chk("b2b_rdy", 64'(in_ready), 64'd1);
    chk("b2b0_wdi", 64'(wb_wdi), 64'hAAAA_0001);
    chk("b2b0_rn", 64'(wb_rn), 64'd3);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b1_wdi", 64'(wb_wdi), 64'hBBBB_0002);
    chk("b2b1_rn", 64'(wb_rn), 64'd4);
    chk("b2b1_we", 64'(wb_we), 64'd1);
    tick();
    chk("b2b_cnt", 64'(retire_cnt), 64'd9);

    // Stall three cycles with a new instruction waiting, then flush
    in_valid = 1'b1;
    in_r_alu = 32'h0000_0077;
    in_rn    = 5'd7;
    tick();
    stall    = 1'b1;
    in_r_alu = 32'h0000_0088;
    in_rn    = 5'd8;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stl_we", 64'(wb_we), 64'd0);
      chk("stl_rdy", 64'(in_ready), 64'd0);
      chk("stl_rn", 64'(wb_rn), 64'd7);
      if (i < 2) tick();
    end
    tick();
    stall = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_we", 64'(wb_we), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_after_we", 64'(wb_we), 64'd0);
    chk("fl_after_rn", 64'(wb_rn), 64'd7);
    chk("fl_cnt", 64'(retire_cnt), 64'd9);
    tick();
    chk("fl_cnt2", 64'(retire_cnt), 64'd9);

    // Register 0 is never written but still retires
    in_valid = 1'b1;
    in_r_alu = 32'h0000_00FF;
    in_rn    = 5'd0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("r0_we", 64'(wb_we), 64'd0);
    tick();
    chk("r0_cnt", 64'(retire_cnt), 64'd10);

    // Reset with an entry pending: dropped, no write, counter cleared
    in_valid = 1'b1;
    in_rn    = 5'd6;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mrst_we", 64'(wb_we), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_cnt", 64'(retire_cnt), 64'd0);
    chk("mrst_rn", 64'(wb_rn), 64'd0);
    tick();
    chk("mrst_we2", 64'(wb_we), 64'd0);

    // Stream 2^CNT_W commits; the counter wraps back to zero
    in_valid = 1'b1;
    in_rn    = 5'd1;
    for (int i = 0; i < 256; i++) begin
      in_r_alu = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap_pre", 64'(retire_cnt), 64'd255);
    chk("wrap_wdi", 64'(wb_wdi), 64'd255);
    tick();
    chk("wrap_cnt", 64'(retire_cnt), 64'd0);

`ifdef WB_BYPASS_EN
    // Bypass holds the committed write for exactly one cycle
    in_valid = 1'b1;
    in_r_alu = 32'h0000_00A5;
    in_rn    = 5'd9;
    tick();
    in_valid = 1'b0;
    #1;
    chk("byp_pre", 64'(byp_valid), 64'd0);
    tick();
    chk("byp_v", 64'(byp_valid), 64'd1);
    chk("byp_rn", 64'(byp_rn), 64'd9);
    chk("byp_data", 64'(byp_data), 64'h0000_00A5);
    tick();
    chk("byp_drop", 64'(byp_valid), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
